// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_responder
// Description : Memory-side responder for the load/store unit. Holds a
//               word-organised data array, commits byte/half/word stores with
//               lane masking and returns load data right-justified.
//               Sequenced by a small FSM with programmable read wait states.
//               Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word
//               stores are dropped and flagged on the misaligned output.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        read,
    input  logic [31:0] read_address,
    input  logic        write,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [1:0]  size,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        busy,
    output logic        misaligned
);

    localparam int       c_DEPTH  = 2 ** ADDR_BITS;
    localparam bit [3:0] c_LAT_M1 = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RESP    = 2'd2
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [ADDR_BITS-1:0]   r_rd_idx;
    logic [1:0]             r_rd_off;
    logic [31:0]            r_data_out;
    logic                   r_ack;
    logic                   r_busy;
    logic                   r_misaligned;
    logic [31:0]            r_mem [c_DEPTH];

    logic [ADDR_BITS-1:0]   w_wr_idx;
    logic [1:0]             w_wr_off;
    logic                   w_wr_misaligned;
    logic                   w_accept_wr;
    logic                   w_store_en;
    logic [31:0]            w_merged;
    logic [ADDR_BITS-1:0]   w_src_idx;
    logic [1:0]             w_src_off;
    logic [31:0]            w_load_val;
    logic                   w_unused_bits;

    // Upper address bits wrap away by design.
    assign w_unused_bits = ^{read_address[31:ADDR_BITS+2], write_address[31:ADDR_BITS+2]};

    assign w_wr_idx = write_address[ADDR_BITS+1:2];
    assign w_wr_off = write_address[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_wr_misaligned = ((size == 2'b10) && w_wr_off[0]) ||
                             ((size == 2'b11) && (w_wr_off != 2'b00));
`else
    assign w_wr_misaligned = 1'b0;
`endif

    // Writes are only taken in IDLE; write beats read when both are asserted.
    assign w_accept_wr = (r_state == S_IDLE) && (write == 1'b1);
    assign w_store_en  = reset_n && w_accept_wr && !w_wr_misaligned && (size != 2'b00);

    // Merge the selected store lanes into the current word contents.
    always_comb begin
        w_merged = r_mem[w_wr_idx];
        case (size)
            2'b01:   w_merged[8*w_wr_off +: 8] = write_data[7:0];
            2'b10: begin
                if (w_wr_off[1]) w_merged[31:16] = write_data[15:0];
                else             w_merged[15:0]  = write_data[15:0];
            end
            2'b11:   w_merged = write_data;
            default: w_merged = r_mem[w_wr_idx];
        endcase
    end

    // With zero wait states the load completes straight from IDLE, so the
    // live address is used; otherwise the index latched at acceptance.
    assign w_src_idx  = (r_state == S_IDLE) ? read_address[ADDR_BITS+1:2] : r_rd_idx;
    assign w_src_off  = (r_state == S_IDLE) ? read_address[1:0]           : r_rd_off;
    assign w_load_val = r_mem[w_src_idx] >> {w_src_off, 3'b000};

    // Data array: no reset, contents survive reset_n.
    always_ff @(posedge clk) begin
        if (w_store_en) r_mem[w_wr_idx] <= w_merged;
    end

    // Request sequencer with registered ack/busy/misaligned/data_out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_rd_idx     <= '0;
            r_rd_off     <= 2'b00;
            r_data_out   <= 32'd0;
            r_ack        <= 1'b0;
            r_busy       <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_ack        <= 1'b0;
            r_busy       <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (write == 1'b1) begin
                        r_state      <= S_RESP;
                        r_ack        <= 1'b1;
                        r_misaligned <= w_wr_misaligned;
                    end else if (read == 1'b1) begin
                        r_rd_idx <= read_address[ADDR_BITS+1:2];
                        r_rd_off <= read_address[1:0];
                        r_cnt    <= c_LAT_M1;
                        if (c_LAT_M1 == 4'd0) begin
                            r_state    <= S_RESP;
                            r_ack      <= 1'b1;
                            r_data_out <= w_load_val;
                        end else begin
                            r_state <= S_RD_WAIT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RD_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state    <= S_RESP;
                        r_ack      <= 1'b1;
                        r_data_out <= w_load_val;
                    end else begin
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign ack        = r_ack;
    assign busy       = r_busy;
    assign misaligned = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_responder
// Description : Self-checking bench. Instance 0 uses READ_LATENCY=1 and runs a
//               table of store/load vectors; instance 1 uses READ_LATENCY=4
//               for wait-state, busy-ignore and mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] raddr [2];
    logic [31:0] waddr [2];
    logic [31:0] wdata [2];
    logic [1:0]  sz    [2];
    logic [31:0] dout  [2];
    logic        ack   [2];
    logic        busy  [2];
    logic        mis   [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.ADDR_BITS(10), .READ_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .read(rd[0]), .read_address(raddr[0]),
        .write(wr[0]), .write_address(waddr[0]), .write_data(wdata[0]), .size(sz[0]),
        .data_out(dout[0]), .ack(ack[0]), .busy(busy[0]), .misaligned(mis[0])
    );

    data_memory_responder #(.ADDR_BITS(10), .READ_LATENCY(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .read(rd[1]), .read_address(raddr[1]),
        .write(wr[1]), .write_address(waddr[1]), .write_data(wdata[1]), .size(sz[1]),
        .data_out(dout[1]), .ack(ack[1]), .busy(busy[1]), .misaligned(mis[1])
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one request (called while the DUT is IDLE) and waits, bounded,
    // for its ack; lat=0 means no ack arrived.
    task automatic do_req(input int d, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] s, output int lat);
        rd[d] = r; wr[d] = w; raddr[d] = a; waddr[d] = a; wdata[d] = wd; sz[d] = s;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ack[d] === 1'b1) begin
                lat = c;
                break;
            end
        end
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    // Request plus latency, data, no-trap and single-ack checks; leaves DUT IDLE.
    task automatic txn(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] s,
                       input int exp_lat, input logic [31:0] exp_dout);
        int lat;
        do_req(d, r, w, a, wd, s, lat);
        chk("ack_latency", 32'(lat), 32'(exp_lat));
        chk("data_out", dout[d], exp_dout);
        chk("misaligned", {31'd0, mis[d]}, 32'd0);
        @(posedge clk); #1;
        chk("single_ack", {31'd0, ack[d]}, 32'd0);
    endtask

    initial begin
        int lat;
        int acks;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b11, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344, 2'b11, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0013, 32'hFFFF_FFAA, 2'b01, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 2'b00, 32'hAA22_3344};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 2'b00, 32'h0000_00AA};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 2'b00, 32'h0000_AA22};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h5566_7788, 2'b11, 32'h0000_AA22};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0022, 32'h1234_BEEF, 2'b10, 32'h0000_AA22};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 2'b00, 32'hBEEF_7788};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0021, 32'h0000_0000, 2'b00, 32'h00BE_EF77};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0021, 32'h0000_CAFE, 2'b10, 32'h00BE_EF77};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 2'b00, 32'hBEEF_CAFE};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_0027, 32'h0BAD_F00D, 2'b11, 32'hBEEF_CAFE};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_0024, 32'h0000_0000, 2'b00, 32'h0BAD_F00D};
        vecs[15] = '{1'b0, 1'b1, 32'h0000_1010, 32'hA5A5_A5A5, 2'b11, 32'h0BAD_F00D};
        vecs[16] = '{1'b1, 1'b0, 32'hFFFF_F010, 32'h0000_0000, 2'b00, 32'hA5A5_A5A5};
        vecs[17] = '{1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 2'b00, 32'hA5A5_A5A5};
        vecs[18] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 2'b00, 32'hA5A5_A5A5};
        vecs[19] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0005, 2'b11, 32'hA5A5_A5A5};
        vecs[20] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 2'b00, 32'h0000_0005};
        vecs[21] = '{1'b1, 1'b0, 32'h0000_0024, 32'h0000_0000, 2'b00, 32'h0BAD_F00D};
        vecs[22] = '{1'b0, 1'b1, 32'h0000_0025, 32'h0000_00EE, 2'b01, 32'h0BAD_F00D};
        vecs[23] = '{1'b1, 1'b0, 32'h0000_0024, 32'h0000_0000, 2'b00, 32'h0BAD_EE0D};
        vecs[24] = '{1'b1, 1'b0, 32'h0000_0026, 32'h0000_0000, 2'b00, 32'h0000_0BAD};

        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; raddr[d] = '0; waddr[d] = '0; wdata[d] = '0; sz[d] = 2'b00;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ack", {31'd0, ack[d]}, 32'd0);
            chk("reset_busy", {31'd0, busy[d]}, 32'd0);
            chk("reset_misaligned", {31'd0, mis[d]}, 32'd0);
            chk("reset_data_out", dout[d], 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Table of single-cycle-latency transactions.
        for (int i = 0; i < 25; i++) begin
            txn(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size,
                1, vecs[i].exp_dout);
        end

        // READ_LATENCY=4: busy window, ignored store while busy, single ack.
        txn(1, 1'b0, 1'b1, 32'h40, 32'h1111_1111, 2'b11, 1, 32'h0);
        rd[1] = 1'b1; raddr[1] = 32'h40;
        @(posedge clk); #1;
        chk("rl4_busy_t1", {30'd0, busy[1], ack[1]}, 32'd2);
        wr[1] = 1'b1; waddr[1] = 32'h40; wdata[1] = 32'h2222_2222; sz[1] = 2'b11;
        @(posedge clk); #1;
        chk("rl4_busy_t2", {30'd0, busy[1], ack[1]}, 32'd2);
        wr[1] = 1'b0;
        @(posedge clk); #1;
        chk("rl4_busy_t3", {30'd0, busy[1], ack[1]}, 32'd2);
        @(posedge clk); #1;
        chk("rl4_ack_t4", {30'd0, busy[1], ack[1]}, 32'd1);
        chk("rl4_data", dout[1], 32'h1111_1111);
        rd[1] = 1'b0;
        @(posedge clk); #1;
        chk("rl4_no_second_ack_a", {31'd0, ack[1]}, 32'd0);
        @(posedge clk); #1;
        chk("rl4_no_second_ack_b", {31'd0, ack[1]}, 32'd0);
        txn(1, 1'b1, 1'b0, 32'h40, 32'h0, 2'b00, 4, 32'h1111_1111);

        // Reset while a load waits: no ack, busy drops at once, array kept.
        txn(1, 1'b0, 1'b1, 32'h44, 32'h3333_3333, 2'b11, 1, 32'h1111_1111);
        rd[1] = 1'b1; raddr[1] = 32'h44;
        @(posedge clk); #1;
        chk("rst_pre_busy", {31'd0, busy[1]}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy_now", {31'd0, busy[1]}, 32'd0);
        chk("rst_ack_now", {31'd0, ack[1]}, 32'd0);
        chk("rst_data_out", dout[1], 32'd0);
        rd[1] = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ack[1] === 1'b1) acks++;
        end
        chk("rst_no_ack", 32'(acks), 32'd0);
        txn(1, 1'b1, 1'b0, 32'h44, 32'h0, 2'b00, 4, 32'h3333_3333);
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b00, 1, 32'hA5A5_A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
